// File: rtl/counter8_down.sv
// counter8_down: loadable 3-bit down-counter with an active-low seven-segment
// encoder. It counts 7 -> 0, then wraps to 7 or stops, depending on iOneShot.
// oTc pulses for one cycle when the count reaches 0 by counting down.
// An optional prescaler divides the count rate by PRESCALE_DIV.
// Optional feature macro: COUNTER8_DOWN_BLANK_EN. When it is defined, the
// display is blanked while oDone is set.
module counter8_down #(
  parameter int         PRESCALE_DIV = 1,
  parameter logic [2:0] RESET_VAL    = 3'd7
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       iEn,
  input  logic       iLoad,
  input  logic [2:0] iLoadVal,
  input  logic       iOneShot,
  output logic [2:0] oQ,
  output logic [6:0] oDisplay,
  output logic       oTc,
  output logic       oDone
);

  // The prescaler is never narrower than one bit. With PRESCALE_DIV = 1 the
  // prescaler sits at 0 and every enabled cycle is a tick.
  localparam int            PW      = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE_DIV - 1);

  // Segment patterns are active-low, with bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_code(input logic [2:0] v);
    logic [6:0] s;
    case (v)
      3'd0:    s = 7'h40;
      3'd1:    s = 7'h79;
      3'd2:    s = 7'h24;
      3'd3:    s = 7'h30;
      3'd4:    s = 7'h19;
      3'd5:    s = 7'h12;
      3'd6:    s = 7'h02;
      3'd7:    s = 7'h78;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [PW-1:0] ps_q, ps_d;
  logic [2:0]    q_q, q_d;
  logic [6:0]    disp_q, disp_d;
  logic          tc_q, tc_d;
  logic          done_q, done_d;
  logic          tick_s;

  // A tick occurs on the enabled cycle in which the prescaler wraps.
  always_comb begin
    tick_s = iEn && (ps_q == PS_LAST);
  end

  // Prescaler: cleared by a load. It wraps on a tick and holds while disabled.
  always_comb begin
    ps_d = ps_q;
    if (iLoad) begin
      ps_d = '0;
    end else if (tick_s) begin
      ps_d = '0;
    end else if (iEn) begin
      ps_d = ps_q + PW'(1);
    end else begin
      ps_d = ps_q;
    end
  end

  // Count/done/tc next state. A load wins over a tick. A set done flag
  // freezes the count at 0 until the next load.
  always_comb begin
    q_d    = q_q;
    done_d = done_q;
    tc_d   = 1'b0;
    if (iLoad) begin
      q_d    = iLoadVal;
      done_d = 1'b0;
    end else if (tick_s) begin
      if (q_q > 3'd1) begin
        q_d = q_q - 3'd1;
      end else if (q_q == 3'd1) begin
        q_d  = 3'd0;
        tc_d = 1'b1;
        if (iOneShot) begin
          done_d = 1'b1;
        end else begin
          done_d = done_q;
        end
      end else if (done_q) begin
        q_d = q_q;
      end else if (iOneShot) begin
        done_d = 1'b1;
      end else begin
        q_d = 3'd7;
      end
    end else begin
      q_d = q_q;
    end
  end

  // The display is encoded from the next count, so it changes on the same
  // edge as oQ.
  always_comb begin
    disp_d = seg_code(q_d);
`ifdef COUNTER8_DOWN_BLANK_EN
    if (done_d) begin
      disp_d = 7'h7F;
    end else begin
      disp_d = seg_code(q_d);
    end
`else
    disp_d = seg_code(q_d);
`endif
  end

  // State registers. The reset is asynchronous.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ps_q   <= '0;
      q_q    <= RESET_VAL;
      disp_q <= seg_code(RESET_VAL);
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      q_q    <= q_d;
      disp_q <= disp_d;
      tc_q   <= tc_d;
      done_q <= done_d;
    end
  end

  assign oQ       = q_q;
  assign oDisplay = disp_q;
  assign oTc      = tc_q;
  assign oDone    = done_q;

endmodule

// File: tb/tb_counter8_down.sv
// Directed self-checking bench for counter8_down.
// Instance u_a uses PRESCALE_DIV=1. Instance u_b uses PRESCALE_DIV=4.
// Both instances share the same stimulus.
module tb_counter8_down;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [2:0] load_val;
  logic       one_shot;
  logic [2:0] a_q, b_q;
  logic [6:0] a_disp, b_disp;
  logic       a_tc, b_tc, a_done, b_done;

  int checks = 0;
  int errors = 0;

  logic [2:0] wq [0:7] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
  logic [7:0] wd [0:7] = '{8'h02, 8'h12, 8'h19, 8'h30, 8'h24, 8'h79, 8'h40, 8'h78};
  logic       ben [0:10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [2:0] bq  [0:10] = '{3'd7, 3'd7, 3'd7, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd5};
  logic [2:0] lq  [0:5]  = '{3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd6};

  counter8_down #(.PRESCALE_DIV(1)) u_a (
    .CLK(clk), .rst_n(rst_n), .iEn(en), .iLoad(load), .iLoadVal(load_val),
    .iOneShot(one_shot), .oQ(a_q), .oDisplay(a_disp), .oTc(a_tc), .oDone(a_done)
  );

  counter8_down #(.PRESCALE_DIV(4)) u_b (
    .CLK(clk), .rst_n(rst_n), .iEn(en), .iLoad(load), .iLoadVal(load_val),
    .iOneShot(one_shot), .oQ(b_q), .oDisplay(b_disp), .oTc(b_tc), .oDone(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] seg(input logic [2:0] v);
    case (v)
      3'd0:    return 8'h40;
      3'd1:    return 8'h79;
      3'd2:    return 8'h24;
      3'd3:    return 8'h30;
      3'd4:    return 8'h19;
      3'd5:    return 8'h12;
      3'd6:    return 8'h02;
      default: return 8'h78;
    endcase
  endfunction

  function automatic logic [7:0] exp_disp(input logic [2:0] q, input logic done);
`ifdef COUNTER8_DOWN_BLANK_EN
    if (done) return 8'h7F;
`endif
    return seg(q);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [2:0] q, input logic tc, input logic done);
    check({tag, ".q"},    {5'd0, a_q},    {5'd0, q});
    check({tag, ".disp"}, {1'b0, a_disp}, exp_disp(q, done));
    check({tag, ".tc"},   {7'd0, a_tc},   {7'd0, tc});
    check({tag, ".done"}, {7'd0, a_done}, {7'd0, done});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = 3'd0; one_shot = 1'b0;
    #20;
    chk_a("reset_a", 3'd7, 1'b0, 1'b0);
    check("reset_b.q", {5'd0, b_q}, 8'd7);
    check("reset_b.disp", {1'b0, b_disp}, 8'h78);

    // Wrap mode with DIV=1.
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("wrap.q", {5'd0, a_q}, {5'd0, wq[i]});
      check("wrap.disp", {1'b0, a_disp}, wd[i]);
      check("wrap.tc", {7'd0, a_tc}, (wq[i] == 3'd0) ? 8'd1 : 8'd0);
    end

    // One-shot mode: count from 7 down to 0, then stay there.
    one_shot = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk_a("oneshot", 3'(6 - i), (i == 6), (i == 6));
    end
    for (int i = 0; i < 10; i++) begin
      step();
      chk_a("oneshot_hold", 3'd0, 1'b0, 1'b1);
    end
    one_shot = 1'b0;
    step();
    chk_a("done_sticky", 3'd0, 1'b0, 1'b1);

    // Loads: they exit done, they override a coincident tick, and a load of
    // 0 does not pulse oTc.
    load = 1'b1; load_val = 3'd4;
    step();
    chk_a("load4", 3'd4, 1'b0, 1'b0);
    load = 1'b0;
    step();
    chk_a("after_load4", 3'd3, 1'b0, 1'b0);
    load = 1'b1; load_val = 3'd5;
    step();
    chk_a("load_prio", 3'd5, 1'b0, 1'b0);
    load_val = 3'd0;
    step();
    chk_a("load0", 3'd0, 1'b0, 1'b0);
    load = 1'b0;
    step();
    chk_a("wrap_from_load0", 3'd7, 1'b0, 1'b0);
    load = 1'b1; one_shot = 1'b1;
    step();
    load = 1'b0;
    step();
    chk_a("oneshot_load0", 3'd0, 1'b0, 1'b1);
    en = 1'b0; load = 1'b1; load_val = 3'd3; one_shot = 1'b0;
    step();
    chk_a("load_disabled", 3'd3, 1'b0, 1'b0);
    load = 1'b0;
    step();
    chk_a("frozen", 3'd3, 1'b0, 1'b0);
    en = 1'b1;
    step();
    chk_a("pre_async", 3'd2, 1'b0, 1'b0);

    // Asynchronous reset, asserted between clock edges.
    #3;
    rst_n = 1'b0;
    #1;
    chk_a("async_rst", 3'd7, 1'b0, 1'b0);

    // Prescaler with DIV=4, including three frozen cycles.
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b1; one_shot = 1'b0; load = 1'b0;
    for (int i = 0; i < 11; i++) begin
      en = ben[i];
      step();
      check("presc.q", {5'd0, b_q}, {5'd0, bq[i]});
      check("presc.tc", {7'd0, b_tc}, 8'd0);
    end
    check("presc.disp", {1'b0, b_disp}, 8'h12);

    // A load clears the prescaler: the next tick comes 4 cycles after the load.
    for (int i = 0; i < 6; i++) begin
      load = (i == 2); load_val = 3'd6;
      step();
      check("presc_load.q", {5'd0, b_q}, {5'd0, lq[i]});
    end
    load = 1'b0;
    step();
    check("presc_load.tick", {5'd0, b_q}, 8'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
